// File: rtl/hash_capture.sv
// Captures one digest from the Pmod hash byte stream into a local buffer and
// compares it against an expected digest, flagging short and overrun frames.
module hash_capture #(
   parameter  int PMOD_W     = 8,
   parameter  int HASH_BYTES = 32,
   parameter  int CNT_W      = 16,
   localparam int AW         = $clog2(HASH_BYTES),
   localparam int BW         = AW + 1
) (
   input  logic                         clk,
   input  logic                         rst_async,
   input  logic [PMOD_W-1:0]            hash_i,
   input  logic [1:0]                   hash_ctrl_i,
   input  logic [HASH_BYTES*PMOD_W-1:0] expected_i,
   input  logic                         arm_i,
   output logic                         done_o,
   output logic                         match_o,
   output logic                         error_o,
   output logic [1:0]                   err_code_o,
   output logic [BW-1:0]                byte_cnt_o,
   output logic [CNT_W-1:0]             frame_cnt_o,
   input  logic [AW-1:0]                rd_addr_i,
   output logic [PMOD_W-1:0]            rd_data_o
);

   typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

   localparam logic [1:0] ERR_NONE  = 2'b00;
   localparam logic [1:0] ERR_SHORT = 2'b01;
   localparam logic [1:0] ERR_OVER  = 2'b10;

   state_t              state_reg, state_next;
   logic [PMOD_W-1:0]   b_reg;
   logic                v_reg, l_reg;
   logic [BW-1:0]       byte_cnt_reg, byte_cnt_next;
   logic                acc_reg, acc_next;
   logic [1:0]          err_reg, err_next;
   logic [CNT_W-1:0]    frame_cnt_reg;
   logic [PMOD_W-1:0]   buf_mem [HASH_BYTES];
   logic [PMOD_W-1:0]   rd_data_reg;
   logic                wr_en;
   logic                full;
   logic [AW-1:0]       wr_idx;
   logic [BW-1:0]       cnt_inc;

   assign full    = (byte_cnt_reg == BW'(HASH_BYTES));
   assign wr_idx  = byte_cnt_reg[AW-1:0];
   assign cnt_inc = byte_cnt_reg + BW'(1);

   always_ff @(posedge clk or posedge rst_async) begin
      if (rst_async) begin
         b_reg <= '0;
         v_reg <= 1'b0;
         l_reg <= 1'b0;
      end else begin
         b_reg <= hash_i;
         v_reg <= hash_ctrl_i[0];
         l_reg <= hash_ctrl_i[1];
      end
   end

   // arm has priority over any byte processed in the same cycle
   always_comb begin
      state_next    = state_reg;
      byte_cnt_next = byte_cnt_reg;
      acc_next      = acc_reg;
      err_next      = err_reg;
      wr_en         = 1'b0;
      if (arm_i) begin
         state_next    = CAPTURE;
         byte_cnt_next = '0;
         acc_next      = 1'b1;
         err_next      = ERR_NONE;
      end else if (state_reg == CAPTURE && v_reg) begin
         if (full) begin
            state_next = DONE;
            err_next   = ERR_OVER;
         end else begin
            wr_en         = 1'b1;
            acc_next      = acc_reg & (b_reg == expected_i[wr_idx*PMOD_W +: PMOD_W]);
            byte_cnt_next = cnt_inc;
            if (l_reg) begin
               state_next = DONE;
               err_next   = (cnt_inc == BW'(HASH_BYTES)) ? ERR_NONE : ERR_SHORT;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst_async) begin
      if (rst_async) begin
         state_reg     <= IDLE;
         byte_cnt_reg  <= '0;
         acc_reg       <= 1'b0;
         err_reg       <= ERR_NONE;
         frame_cnt_reg <= '0;
      end else begin
         state_reg    <= state_next;
         byte_cnt_reg <= byte_cnt_next;
         acc_reg      <= acc_next;
         err_reg      <= err_next;
         if (state_next == DONE && state_reg != DONE)
            frame_cnt_reg <= frame_cnt_reg + CNT_W'(1);
      end
   end

   // buffer survives arm; only reset clears it
   always_ff @(posedge clk or posedge rst_async) begin
      if (rst_async) begin
         for (int i = 0; i < HASH_BYTES; i++)
            buf_mem[i] <= '0;
      end else if (wr_en) begin
         buf_mem[wr_idx] <= b_reg;
      end
   end

   always_ff @(posedge clk or posedge rst_async) begin
      if (rst_async)
         rd_data_reg <= '0;
      else if ({1'b0, rd_addr_i} < BW'(HASH_BYTES))
         rd_data_reg <= buf_mem[rd_addr_i];
      else
         rd_data_reg <= '0;
   end

   assign done_o      = (state_reg == DONE);
   assign match_o     = done_o & acc_reg & (err_reg == ERR_NONE);
   assign error_o     = done_o & (err_reg != ERR_NONE);
   assign err_code_o  = err_reg;
   assign byte_cnt_o  = byte_cnt_reg;
   assign frame_cnt_o = frame_cnt_reg;
   assign rd_data_o   = rd_data_reg;

endmodule

// File: tb/tb_hash_capture.sv
// Scoreboard bench for hash_capture: frame outcomes are predicted from the
// byte list and compared by a monitor whenever done_o rises.
module tb_hash_capture;
   localparam int HB = 32;

   logic          clk = 1'b0;
   logic          rst_async;
   logic [7:0]    hash_i;
   logic [1:0]    hash_ctrl_i;
   logic [HB*8-1:0] expected_i;
   logic          arm_i;
   logic          done_o, match_o, error_o;
   logic [1:0]    err_code_o;
   logic [5:0]    byte_cnt_o;
   logic [15:0]   frame_cnt_o;
   logic [4:0]    rd_addr_i;
   logic [7:0]    rd_data_o;

   always #5 clk = ~clk;

   hash_capture #(.PMOD_W(8), .HASH_BYTES(HB), .CNT_W(16)) dut (
      .clk(clk), .rst_async(rst_async), .hash_i(hash_i), .hash_ctrl_i(hash_ctrl_i),
      .expected_i(expected_i), .arm_i(arm_i), .done_o(done_o), .match_o(match_o),
      .error_o(error_o), .err_code_o(err_code_o), .byte_cnt_o(byte_cnt_o),
      .frame_cnt_o(frame_cnt_o), .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o)
   );

   typedef struct {
      bit         m;
      bit         e;
      logic [1:0] code;
      int         cnt;
      int         fc;
   } exp_t;

   exp_t       sb[$];
   int         vectors = 0;
   int         miscompares = 0;
   logic [7:0] mbuf [HB];
   logic [7:0] fdata [40];
   int         fc_m = 0;
   logic       done_prev = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // monitor: one outcome popped per rising done_o
   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst_async && done_o && !done_prev) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", {31'd0, done_o}, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("match", {31'd0, match_o}, {31'd0, e.m});
            chk("error", {31'd0, error_o}, {31'd0, e.e});
            chk("err_code", {30'd0, err_code_o}, {30'd0, e.code});
            chk("byte_cnt", {26'd0, byte_cnt_o}, e.cnt);
            chk("frame_cnt", {16'd0, frame_cnt_o}, e.fc);
            $display("frame: cnt=%0d code=%0b match=%0b fc=%0d", byte_cnt_o, err_code_o, match_o, frame_cnt_o);
         end
      end
      done_prev = done_o;
   end

   task automatic drive(input logic v, input logic l, input logic [7:0] b);
      @(negedge clk);
      hash_i      = b;
      hash_ctrl_i = {l, v};
   endtask

   task automatic arm();
      @(negedge clk);
      hash_ctrl_i = 2'b00;
      arm_i       = 1'b1;
      @(negedge clk);
      arm_i       = 1'b0;
   endtask

   task automatic rd_check(input int addr, input logic [7:0] req);
      @(negedge clk);
      rd_addr_i = addr[4:0];
      @(negedge clk);
      chk($sformatf("rd[%0d]", addr), {24'd0, rd_data_o}, {24'd0, req});
   endtask

   task automatic set_seq(input int base);
      for (int i = 0; i < HB; i++) begin
         fdata[i] = 8'(base + i);
         expected_i[8*i +: 8] = 8'(base + i);
      end
   endtask

   // outcome follows from frame length and content alone
   task automatic run_frame(input int n, input bit with_last, input bit gaps);
      exp_t e;
      int   stored;
      bit   eq;
      arm();
      stored = (n > HB) ? HB : n;
      for (int i = 0; i < stored; i++) mbuf[i] = fdata[i];
      e.cnt  = stored;
      e.code = (n > HB) ? 2'b10 : ((n < HB) ? 2'b01 : 2'b00);
      e.e    = (e.code != 2'b00);
      eq = 1'b1;
      for (int i = 0; i < HB; i++)
         if (fdata[i] !== expected_i[8*i +: 8]) eq = 1'b0;
      e.m  = (e.code == 2'b00) && eq;
      fc_m = (fc_m + 1) & 16'hFFFF;
      e.fc = fc_m;
      sb.push_back(e);
      for (int i = 0; i < n; i++) begin
         if (gaps && $urandom_range(0, 3) == 0) drive(1'b0, 1'b0, 8'($urandom));
         drive(1'b1, with_last && (i == n - 1), fdata[i]);
      end
      drive(1'b0, 1'b0, 8'h00);
      for (int k = 0; k < 8 && sb.size() != 0; k++) @(negedge clk);
      chk("pending_outcomes", sb.size(), 0);
      sb.delete();
   endtask

   initial begin
      rst_async   = 1'b1;
      hash_i      = '0;
      hash_ctrl_i = '0;
      expected_i  = '0;
      arm_i       = 1'b0;
      rd_addr_i   = '0;
      for (int i = 0; i < HB; i++) mbuf[i] = 8'h00;
      repeat (2) @(negedge clk);
      chk("rst_done", {31'd0, done_o}, 0);
      chk("rst_match", {31'd0, match_o}, 0);
      chk("rst_error", {31'd0, error_o}, 0);
      chk("rst_err_code", {30'd0, err_code_o}, 0);
      chk("rst_byte_cnt", {26'd0, byte_cnt_o}, 0);
      chk("rst_frame_cnt", {16'd0, frame_cnt_o}, 0);
      chk("rst_rd_data", {24'd0, rd_data_o}, 0);
      rst_async = 1'b0;

      // valid bytes in IDLE are ignored
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'hAA);
      drive(1'b0, 1'b0, 8'h00);
      repeat (2) @(negedge clk);
      chk("idle_done", {31'd0, done_o}, 0);
      chk("idle_byte_cnt", {26'd0, byte_cnt_o}, 0);
      rd_check(0, mbuf[0]);

      set_seq(0);
      run_frame(HB, 1'b1, 1'b0);
      rd_check(0, mbuf[0]);
      rd_check(31, mbuf[31]);

      fdata[17] = 8'hFF;
      run_frame(HB, 1'b1, 1'b0);
      rd_check(17, 8'hFF);

      set_seq(8'h80);
      run_frame(10, 1'b1, 1'b0);
      rd_check(9, mbuf[9]);
      rd_check(10, mbuf[10]);

      set_seq(8'h40);
      fdata[32] = 8'h99;
      run_frame(HB + 1, 1'b0, 1'b1);
      for (int a = 0; a < HB; a++) rd_check(a, mbuf[a]);

      // abort mid-frame with arm
      set_seq(8'h10);
      arm();
      for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, fdata[i]);
      drive(1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 5; i++) mbuf[i] = fdata[i];
      @(negedge clk);
      chk("abort_pre_cnt", {26'd0, byte_cnt_o}, 5);
      arm_i = 1'b1;
      @(negedge clk);
      arm_i = 1'b0;
      chk("abort_cnt", {26'd0, byte_cnt_o}, 0);
      rd_check(4, mbuf[4]);

      // arm coinciding with the last byte discards the frame
      set_seq(8'h20);
      arm();
      for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, fdata[i]);
      drive(1'b1, 1'b1, fdata[7]);
      arm();
      for (int i = 0; i < 7; i++) mbuf[i] = fdata[i];
      repeat (3) @(negedge clk);
      chk("arm_last_done", {31'd0, done_o}, 0);
      chk("arm_last_cnt", {26'd0, byte_cnt_o}, 0);
      chk("arm_last_fc", {16'd0, frame_cnt_o}, fc_m);
      rd_check(7, mbuf[7]);

      for (int t = 0; t < 20; t++) begin
         int kind;
         for (int i = 0; i < HB; i++) begin
            expected_i[8*i +: 8] = 8'($urandom);
            fdata[i] = expected_i[8*i +: 8];
         end
         fdata[32] = 8'($urandom);
         kind = $urandom_range(0, 3);
         if (kind == 1) begin
            int idx;
            idx = $urandom_range(0, HB - 1);
            fdata[idx] = ~fdata[idx];
         end
         case (kind)
            0, 1:    run_frame(HB, 1'b1, 1'b1);
            2:       run_frame($urandom_range(1, HB - 1), 1'b1, 1'b1);
            default: run_frame(HB + 1, 1'b0, 1'b1);
         endcase
         begin
            int a;
            a = $urandom_range(0, HB - 1);
            rd_check(a, mbuf[a]);
         end
      end

      // asynchronous reset in the middle of a frame
      set_seq(8'h60);
      rd_addr_i = 5'd0;
      arm();
      for (int i = 0; i < 12; i++) drive(1'b1, 1'b0, fdata[i]);
      #2 rst_async = 1'b1;
      hash_ctrl_i = 2'b00;
      #1;
      chk("mid_rst_done", {31'd0, done_o}, 0);
      chk("mid_rst_match", {31'd0, match_o}, 0);
      chk("mid_rst_error", {31'd0, error_o}, 0);
      chk("mid_rst_err_code", {30'd0, err_code_o}, 0);
      chk("mid_rst_byte_cnt", {26'd0, byte_cnt_o}, 0);
      chk("mid_rst_frame_cnt", {16'd0, frame_cnt_o}, 0);
      chk("mid_rst_rd_data", {24'd0, rd_data_o}, 0);
      for (int i = 0; i < HB; i++) mbuf[i] = 8'h00;
      fc_m = 0;
      sb.delete();
      @(negedge clk);
      rst_async = 1'b0;
      rd_check(3, 8'h00);
      run_frame(HB, 1'b1, 1'b0);
      rd_check(5, mbuf[5]);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
